// File: rtl/pipe_stall_if.sv
// Stall/flush control bundle between the pipeline stages and the stall scheduler.
// Latency: wires only, with no storage.
// Backpressure: the stall vector it carries is the pipeline's only hold mechanism.
interface pipe_stall_if;
  logic        id_stall_req_i;
  logic        div_start_i;
  logic        div_done_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        exc_valid_i;
  logic [31:0] exc_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        div_cancel_o;
  logic        bus_timeout_o;

  // Pipeline side: raises requests and consumes stall/flush controls.
  modport master (
    output id_stall_req_i, div_start_i, div_done_i, mem_req_i, mem_ack_i,
           exc_valid_i, exc_pc_i,
    input  stall_o, flush_o, new_pc_o, div_cancel_o, bus_timeout_o
  );

  // Scheduler side.
  modport slave (
    input  id_stall_req_i, div_start_i, div_done_i, mem_req_i, mem_ack_i,
           exc_valid_i, exc_pc_i,
    output stall_o, flush_o, new_pc_o, div_cancel_o, bus_timeout_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler: merges RAW, divider and bus-wait stalls; sequences exception flushes.
// Latency: stall_o is combinational; flush/new_pc/div_cancel/bus_timeout are registered, so they lag by 1 cycle.
// Backpressure: an exception arriving during a bus wait is held pending and flushed once the wait ends.
module pipe_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_stall_if.slave pif
);

  typedef enum logic [1:0] {RUN = 2'd0, DIV_WAIT = 2'd1, FLUSH = 2'd2} state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic              exc_pending_q, exc_pending_d;
  logic [31:0]       exc_pc_q, exc_pc_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic              div_cancel_q, div_cancel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_timeout_q, bus_timeout_d;
  logic [5:0]        stall_vec;
  logic              mem_busy;
  logic              exc_take;
  logic [31:0]       exc_target;

  assign mem_busy   = pif.mem_req_i & ~pif.mem_ack_i;
  // A pending exception owns the slot; new pulses are dropped until it flushes.
  assign exc_take   = exc_pending_q | pif.exc_valid_i;
  assign exc_target = exc_pending_q ? exc_pc_q : pif.exc_pc_i;

  // Stall priority, state transitions and exception acceptance.
  always_comb begin
    state_d       = state_q;
    exc_pending_d = exc_pending_q;
    exc_pc_d      = exc_pc_q;
    new_pc_d      = '0;
    div_cancel_d  = 1'b0;
    stall_vec     = 6'b000000;
    case (state_q)
      RUN, DIV_WAIT: begin
        if (mem_busy) begin
          stall_vec = 6'b011111;
        end else if ((state_q == RUN && pif.div_start_i) ||
                     (state_q == DIV_WAIT && !pif.div_done_i)) begin
          stall_vec = 6'b001111;
        end else if (pif.id_stall_req_i) begin
          stall_vec = 6'b000111;
        end

        if (exc_take && !mem_busy) begin
          // Exception beats a divide issued in the same cycle.
          state_d       = FLUSH;
          new_pc_d      = exc_target;
          div_cancel_d  = (state_q == DIV_WAIT) | pif.div_start_i;
          exc_pending_d = 1'b0;
        end else begin
          if (pif.exc_valid_i && !exc_pending_q) begin
            exc_pending_d = 1'b1;
            exc_pc_d      = pif.exc_pc_i;
          end
          if (state_q == RUN && pif.div_start_i) begin
            state_d = DIV_WAIT;
          end else if (state_q == DIV_WAIT && pif.div_done_i) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        // FLUSH is a single cycle; incoming exceptions are ignored here.
        state_d = RUN;
      end
    endcase
  end

  // Consecutive bus-wait counter and registered timeout flag.
  always_comb begin
    cnt_d         = '0;
    bus_timeout_d = 1'b0;
    if (mem_busy) begin
      cnt_d         = (cnt_q == TIMEOUT_CNT) ? cnt_q : cnt_q + 1'b1;
      bus_timeout_d = (cnt_d == TIMEOUT_CNT);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      exc_pending_q <= 1'b0;
      exc_pc_q      <= '0;
      new_pc_q      <= '0;
      div_cancel_q  <= 1'b0;
      cnt_q         <= '0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      exc_pending_q <= exc_pending_d;
      exc_pc_q      <= exc_pc_d;
      new_pc_q      <= new_pc_d;
      div_cancel_q  <= div_cancel_d;
      cnt_q         <= cnt_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

  assign pif.stall_o       = stall_vec;
  assign pif.flush_o       = (state_q == FLUSH);
  assign pif.new_pc_o      = new_pc_q;
  assign pif.div_cancel_o  = div_cancel_q;
  assign pif.bus_timeout_o = bus_timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomised and directed bench for pipe_stall_ctrl with a queue-based scoreboard.
// Latency: expectations are pushed per cycle and checked mid-cycle by a monitor.
// Backpressure: not applicable; the bench drives every cycle.
module tb_pipe_stall_ctrl;
  localparam int TO = 4;

  logic clk;
  logic rst_n;
  pipe_stall_if pif();

  pipe_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        cancel;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_no   = 0;

  // Behavioural model: what the scheduler is doing, in plain terms.
  bit          m_in_div;     // a divide is outstanding
  bit          m_flushing;   // this cycle is the flush cycle
  logic [31:0] m_flush_pc;
  bit          m_cancel;
  bit          m_pend;       // exception waiting for the bus to finish
  logic [31:0] m_pend_pc;
  int          m_busy_run;   // consecutive busy cycles so far
  bit          m_to;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc_no, act, req);
    end
  endtask

  task automatic model_reset();
    m_in_div = 0; m_flushing = 0; m_flush_pc = 0; m_cancel = 0;
    m_pend = 0; m_pend_pc = 0; m_busy_run = 0; m_to = 0;
  endtask

  // One clock of stimulus: drive, predict this cycle's outputs, advance the model.
  task automatic cyc(input bit id, input bit ds, input bit dd, input bit mr,
                     input bit ma, input bit ev, input logic [31:0] pc);
    exp_t e;
    bit busy;
    bit nf;
    logic [31:0] nfpc;
    bit nc;
    @(posedge clk);
    #1;
    cyc_no++;
    pif.id_stall_req_i = id;
    pif.div_start_i    = ds;
    pif.div_done_i     = dd;
    pif.mem_req_i      = mr;
    pif.mem_ack_i      = ma;
    pif.exc_valid_i    = ev;
    pif.exc_pc_i       = pc;
    busy = mr && !ma;

    e.cyc    = cyc_no;
    e.flush  = m_flushing;
    e.pc     = m_flushing ? m_flush_pc : 32'h0;
    e.cancel = m_flushing && m_cancel;
    e.to     = m_to;
    if (m_flushing)                               e.stall = 6'd0;
    else if (busy)                                e.stall = 6'h1f;
    else if ((!m_in_div && ds) || (m_in_div && !dd)) e.stall = 6'h0f;
    else if (id)                                  e.stall = 6'h07;
    else                                          e.stall = 6'd0;
    exp_q.push_back(e);

    nf = 0; nfpc = 0; nc = 0;
    if (m_flushing) begin
      m_in_div = 0;
    end else if ((m_pend || ev) && !busy) begin
      nf = 1;
      nfpc = m_pend ? m_pend_pc : pc;
      nc = m_in_div || ds;
      m_pend = 0;
      m_in_div = 0;
    end else begin
      if (ev && !m_pend) begin
        m_pend = 1;
        m_pend_pc = pc;
      end
      if (!m_in_div && ds) m_in_div = 1;
      else if (m_in_div && dd) m_in_div = 0;
    end
    m_flushing = nf;
    m_flush_pc = nfpc;
    m_cancel   = nc;
    m_busy_run = busy ? m_busy_run + 1 : 0;
    m_to       = busy && (m_busy_run >= TO);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  // Asynchronous reset between clock edges with inputs quiet; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #1;
    pif.id_stall_req_i = 0; pif.div_start_i = 0; pif.div_done_i = 0;
    pif.mem_req_i = 0; pif.mem_ack_i = 0; pif.exc_valid_i = 0; pif.exc_pc_i = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_stall",   32'(pif.stall_o), 32'h0);
    chk("rst_flush",   32'(pif.flush_o), 32'h0);
    chk("rst_new_pc",  pif.new_pc_o, 32'h0);
    chk("rst_cancel",  32'(pif.div_cancel_o), 32'h0);
    chk("rst_timeout", 32'(pif.bus_timeout_o), 32'h0);
    model_reset();
    @(negedge clk);
    #1 rst_n = 1;
  endtask

  // Monitor: compare every cycle's outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_o",       32'(pif.stall_o), 32'(e.stall));
        chk("flush_o",       32'(pif.flush_o), 32'(e.flush));
        chk("new_pc_o",      pif.new_pc_o, e.pc);
        chk("div_cancel_o",  32'(pif.div_cancel_o), 32'(e.cancel));
        chk("bus_timeout_o", 32'(pif.bus_timeout_o), 32'(e.to));
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1;
    model_reset();
    do_reset();

    // RAW hazard for one cycle.
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Divide t0..t4 with a RAW hazard at t2.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(2);

    // Bus wait overlapping a divide and a RAW hazard.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(2);

    // Exception during a divide.
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h8000_0180);
    idle(3);

    // Exception deferred by a bus wait; a later one is dropped.
    cyc(0, 0, 0, 1, 0, 1, 32'h0000_0a00);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 32'h0000_1234);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    idle(3);

    // Exception together with a divide start.
    cyc(0, 1, 0, 0, 0, 1, 32'h0000_0040);
    idle(3);

    // Bus timeout: 8 busy cycles, then ack.
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    idle(2);

    // Reset mid-wait with a divide outstanding and an exception pending.
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, (i == 1), 32'h0000_0bad);
    do_reset();
    idle(3);

    // Random traffic, alternating short requests and long bus waits.
    for (int blk = 0; blk < 20; blk++) begin
      bit long_wait;
      long_wait = (blk % 3 == 2);
      for (int i = 0; i < 30; i++) begin
        bit mr, ma;
        mr = long_wait ? 1'b1 : ($urandom_range(99, 0) < 40);
        ma = long_wait ? ($urandom_range(99, 0) < 15) : ($urandom_range(99, 0) < 40);
        cyc($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 20,
            $urandom_range(99, 0) < 25, mr, ma,
            $urandom_range(99, 0) < 8, $urandom());
      end
    end
    idle(2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
